// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: constants, flag bit positions
// and the operand classifier used by the divide result stage.
package fpu_pkg;

  localparam logic [7:0]  EXP_MAX      = 8'hFF;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

  // Bit positions inside the 4-bit exception flag vector
  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_DZ  = 2;
  localparam int unsigned FLG_OVF = 1;
  localparam int unsigned FLG_UNF = 0;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  // Denormals count as zero; a NaN is signalling when the quiet bit is clear.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    logic [7:0]  e;
    logic [22:0] m;
    e      = x[30:23];
    m      = x[22:0];
    c.zero = (e == 8'h00);
    c.inf  = (e == EXP_MAX) && (m == 23'd0);
    c.nan  = (e == EXP_MAX) && (m != 23'd0);
    c.snan = c.nan && !m[22];
    return c;
  endfunction

endpackage

// File: rtl/fdiv_special_select.sv
// Combinational special-case substitution for the divide result:
// classifies both operands and picks the IEEE result and exception flags.
module fdiv_special_select
  import fpu_pkg::*;
#(
  parameter logic [31:0] QNAN = QNAN_DEFAULT
) (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] raw_result,
  input  logic        raw_uf,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  fp_class_t cls_a;
  fp_class_t cls_b;
  logic      sign;

  assign cls_a = classify(op_a);
  assign cls_b = classify(op_b);
  assign sign  = op_a[31] ^ op_b[31];

  // Priority selection: NaN propagation first, raw datapath result last
  always_comb begin
    result = {sign, raw_result[30:0]};
    flags  = 4'b0000;
    if (cls_a.nan || cls_b.nan) begin
      result         = QNAN;
      flags[FLG_INV] = cls_a.snan | cls_b.snan;
    end else if ((cls_a.zero && cls_b.zero) || (cls_a.inf && cls_b.inf)) begin
      result         = QNAN;
      flags[FLG_INV] = 1'b1;
    end else if (cls_a.inf) begin
      result = {sign, EXP_MAX, 23'd0};
    end else if (cls_b.zero) begin
      result        = {sign, EXP_MAX, 23'd0};
      flags[FLG_DZ] = 1'b1;
    end else if (cls_a.zero || cls_b.inf) begin
      result = {sign, 31'd0};
    end else if (raw_result[30:23] == EXP_MAX) begin
      result         = {sign, EXP_MAX, 23'd0};
      flags[FLG_OVF] = 1'b1;
    end else if (raw_uf || (raw_result[30:23] == 8'h00)) begin
      result         = {sign, 31'd0};
      flags[FLG_UNF] = 1'b1;
    end else begin
      result = {sign, raw_result[30:0]};
    end
  end

endmodule

// File: rtl/fdiv_result_stage.sv
// Divide result stage: special-result substitution, a small in-order output
// queue with valid/ready handshakes, and sticky exception flags.
module fdiv_result_stage
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] QNAN  = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] raw_result,
  input  logic        raw_uf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  input  logic        flags_clear,
  output logic [3:0]  flags_sticky
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [31:0]      sel_result;
  logic [3:0]       sel_flags;
  logic [31:0]      mem_result [DEPTH];
  logic [3:0]       mem_flags  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      head_result_nxt;
  logic [3:0]       head_flags_nxt;
  logic             push;
  logic             pop;

  fdiv_special_select #(.QNAN(QNAN)) u_select (
    .op_a       (op_a),
    .op_b       (op_b),
    .raw_result (raw_result),
    .raw_uf     (raw_uf),
    .result     (sel_result),
    .flags      (sel_flags)
  );

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next pointers, occupancy and the entry that will sit at the head
  always_comb begin
    wr_ptr_nxt = push ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
    rd_ptr_nxt = pop  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({push, pop})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
    // A push lands at the head when it is the only entry left afterwards
    if (push && (wr_ptr_r == rd_ptr_nxt)) begin
      head_result_nxt = sel_result;
      head_flags_nxt  = sel_flags;
    end else begin
      head_result_nxt = mem_result[rd_ptr_nxt];
      head_flags_nxt  = mem_flags[rd_ptr_nxt];
    end
  end

  // Queue storage and pointer/count state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= 32'h0000_0000;
        mem_flags[i]  <= 4'b0000;
      end
    end else begin
      wr_ptr_r <= wr_ptr_nxt;
      rd_ptr_r <= rd_ptr_nxt;
      count_r  <= count_nxt;
      if (push) begin
        mem_result[wr_ptr_r] <= sel_result;
        mem_flags[wr_ptr_r]  <= sel_flags;
      end
    end
  end

  // Registered handshake outputs and head-of-queue presentation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= 32'h0000_0000;
      out_flags  <= 4'b0000;
    end else begin
      in_ready  <= (count_nxt != FULL);
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        out_result <= head_result_nxt;
        out_flags  <= head_flags_nxt;
      end
    end
  end

  // Sticky flags collect popped results; a clear never drops a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_sticky <= 4'b0000;
    end else if (pop) begin
      flags_sticky <= flags_clear ? out_flags : (flags_sticky | out_flags);
    end else if (flags_clear) begin
      flags_sticky <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_fdiv_result_stage.sv
// Scoreboard bench for fdiv_result_stage: directed test-plan vectors,
// backpressure, mid-operation reset and randomized traffic.
module tb_fdiv_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic [31:0] raw_result = 32'h0;
  logic        raw_uf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        flags_clear = 1'b0;
  logic [3:0]  flags_sticky;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] sticky_m = 4'b0000;
  int         total = 0;
  int         bad = 0;
  bit         rand_on;

  fdiv_result_stage #(.DEPTH(2), .QNAN(32'h7FC0_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .raw_result   (raw_result),
    .raw_uf       (raw_uf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .flags_clear  (flags_clear),
    .flags_sticky (flags_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: IEEE divide special cases applied in priority order
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] raw, input logic uf);
    exp_t e;
    logic s, za, zb, ia, ib, na, nb, sa, sb;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sa = na && !a[22];
    sb = nb && !b[22];
    e.f = 4'b0000;
    e.r = {s, raw[30:0]};
    if (na || nb) begin
      e.r = 32'h7FC0_0000;
      e.f = (sa || sb) ? 4'b1000 : 4'b0000;
    end else if ((za && zb) || (ia && ib)) begin
      e.r = 32'h7FC0_0000;
      e.f = 4'b1000;
    end else if (ia) begin
      e.r = {s, 8'hFF, 23'd0};
    end else if (zb) begin
      e.r = {s, 8'hFF, 23'd0};
      e.f = 4'b0100;
    end else if (za || ib) begin
      e.r = {s, 31'd0};
    end else if (raw[30:23] == 8'hFF) begin
      e.r = {s, 8'hFF, 23'd0};
      e.f = 4'b0010;
    end else if (uf || (raw[30:23] == 8'h00)) begin
      e.r = {s, 31'd0};
      e.f = 4'b0001;
    end
    return e;
  endfunction

  // Drive one operand set and wait (bounded) until the stage accepts it
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] raw, input logic uf);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    op_a = a; op_b = b; raw_result = raw; raw_uf = uf;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, raw, uf));
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
          done = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      cycle(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[0] = 1'b1; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rnd_raw();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Monitor: compares head against scoreboard and tracks sticky flags
  always @(negedge clk) begin
    if (!rst) begin
      check("sticky", {28'd0, flags_sticky}, {28'd0, sticky_m});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: out_valid=1 result=%h with no result expected", out_result);
          if (flags_clear) sticky_m = 4'b0000;
        end else begin
          mon_e = exp_q[0];
          check("out_result", out_result, mon_e.r);
          check("out_flags", {28'd0, out_flags}, {28'd0, mon_e.f});
          if (out_ready) begin
            void'(exp_q.pop_front());
            sticky_m = flags_clear ? mon_e.f : (sticky_m | mon_e.f);
          end else if (flags_clear) begin
            sticky_m = 4'b0000;
          end
        end
      end else if (flags_clear) begin
        sticky_m = 4'b0000;
      end
    end
  end

  initial begin
    // Reset state
    cycle(2);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst_sticky", {28'd0, flags_sticky}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    cycle(1);

    // Directed test-plan vectors
    out_ready = 1'b1;
    send(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 1'b0);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    send(32'hBF80_0000, 32'h0000_0000, 32'h1234_5678, 1'b0);
    cycle(3);
    check("dz_sticky", {28'd0, flags_sticky}, 32'h4);
    flags_clear = 1'b1;
    cycle(1);
    flags_clear = 1'b0;
    check("clear_sticky", {28'd0, flags_sticky}, 32'h0);
    send(32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0);
    send(32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h7FC0_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0);
    send(32'h8080_0000, 32'h7F00_0000, 32'h0080_0000, 1'b1);
    send(32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 1'b0);
    drain();

    // Backpressure: two accepts fill the queue, third is held
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0002, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0003, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("held_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_return", {31'd0, in_ready}, 32'd1);
      end
    join
    drain();

    // Reset mid-operation with two entries queued
    out_ready = 1'b0;
    send(32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0);
    cycle(2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sticky", {28'd0, flags_sticky}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    sticky_m = 4'b0000;
    cycle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle(3);
    send(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    drain();

    // Randomized traffic with random backpressure and flag clears
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_op(), rnd_op(), rnd_raw(), ($urandom_range(0, 7) == 0));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          out_ready   = ($urandom_range(0, 2) != 0);
          flags_clear = ($urandom_range(0, 9) == 0);
          cycle(1);
        end
        flags_clear = 1'b0;
      end
    join
    drain();
    cycle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdiv_result_stage.md
Name: fdiv_result_stage

Overview:
- Sequential stage directly downstream of the combinational single-precision divide datapath.
- Registers the raw quotient, classifies the original operands, and substitutes IEEE-754 special results (NaN, signed inf, signed zero) where the raw datapath is not valid.
- Also substitutes results where the raw exponent saturated or underflowed.
- Buffers results in a small output queue with valid/ready handshake and accumulates sticky exception flags for the FPU status register.

Parameters:
- DEPTH, 2, output queue entries; power of two, ≥ 2.
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for every NaN result.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and raw result presented
- in_ready  out  1  stage can accept this cycle
- op_a  in  32  dividend (IEEE single)
- op_b  in  32  divisor (IEEE single)
- raw_result  in  32  quotient from the divide datapath
- raw_uf  in  1  exponent-decrement borrow from the divide datapath (underflow)
- out_valid  out  1  head of queue valid
- out_ready  in  1  consumer accepts head
- out_result  out  32  final quotient
- out_flags  out  4  per-result flags: [3] invalid, [2] div-by-zero, [1] overflow, [0] underflow
- flags_clear  in  1  clear sticky flags
- flags_sticky  out  4  OR of out_flags of every result popped since reset or last clear

Behaviour:
- Reset (async, rst=1):
  - queue empty, count=0, pointers=0
  - out_valid=0, out_result=0, out_flags=0
  - flags_sticky=0, in_ready=1
  - Reset mid-operation discards all queued entries; nothing is emitted after release until a new accept.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH), driven from the count register only; a full queue does not accept even while popping in the same cycle.
- Latency: an accept in cycle N into an empty queue gives out_valid=1 in cycle N+1. Results emerge in strict accept order.
- Operand classification (exp = bits[30:23], man = bits[22:0]):
  - zero: exp==0 (denormals flushed to zero)
  - inf: exp==FF && man==0
  - nan: exp==FF && man!=0
  - snan: nan && man[22]==0
- Sign s = op_a[31] ^ op_b[31].
- Result selection, first match wins:
  1. either operand nan -> QNAN; invalid = either operand snan.
  2. (zero_a & zero_b) | (inf_a & inf_b) -> QNAN; invalid=1.
  3. inf_a -> {s, FF, 0}.
  4. zero_b -> {s, FF, 0}; div-by-zero=1.
  5. zero_a | inf_b -> {s, 31'b0}.
  6. raw_result[30:23]==FF -> {s, FF, 0}; overflow=1.
  7. raw_uf | raw_result[30:23]==0 -> {s, 31'b0}; underflow=1.
  8. otherwise raw_result with bit 31 forced to s.
- Selection is combinational on inputs. The result and flags are written into the queue tail on accept.
- Queue behaviour:
  - Circular, wr_ptr/rd_ptr wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Push into an empty queue with a same-cycle pop is impossible, because out_valid is registered.
  - out_result/out_flags show the head entry; when empty they hold their last value.
- Sticky flags:
  - On pop, flags_sticky |= out_flags.
  - flags_clear alone: flags_sticky=0.
  - flags_clear together with a pop: flags_sticky = popped out_flags (new event not lost).
  - Flags of results accepted but not yet popped are never included.

Decomposition:
- Shared package fpu_pkg:
  - constants EXP_MAX=8'hFF, QNAN_DEFAULT
  - flag bit indices FLG_INV, FLG_DZ, FLG_OVF, FLG_UNF
  - a classify function returning {zero, inf, nan, snan}
- One sub-module, fdiv_special_select: the purely combinational operand classification and priority selection producing {result, flags}.
- The top level holds the queue, count, handshake and sticky-flag logic.

Test Plan:
- 3.0/1.0: op_a=40400000, op_b=3F800000, raw=40400000, out_ready=1 -> next cycle out_result=40400000, out_flags=0000.
- Divide by zero: op_a=BF800000, op_b=00000000 -> FF800000, flags=0100; then flags_sticky=0100 until flags_clear.
- Invalid and NaN: op_a=op_b=00000000 -> 7FC00000, flags=1000. op_a=7F800001 (sNaN) -> 7FC00000, flags=1000. op_a=7FC00001 (qNaN) -> 7FC00000, flags=0000.
- Overflow/underflow: raw=7F800000 with finite operands -> 7F800000, flags=0010. raw_uf=1 with op_a=80800000, op_b=7F000000 -> 80000000, flags=0001.
- Backpressure: out_ready=0, drive three accepts with distinct raw values -> in_ready=0 after 2 accepts, third held. Raise out_ready -> three results in order; in_ready returns the cycle after count drops below DEPTH.
- Reset mid-operation with two entries queued -> out_valid=0 and flags_sticky=0 immediately, in_ready=1; the next accepted result emerges alone.
